// File: rtl/regfile_ab_latch.sv
// Integer register file (32 x 32, 2R/1W, r0 hardwired to zero) with write-to-read
// bypass and the A/B operand latches that feed the ALU in the multicycle datapath.
module regfile_ab_latch #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [DATA_W-1:0] WriteData,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    input  logic              LatchA,
    input  logic              LatchB,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic [DATA_W-1:0] RdData1,
    output logic [DATA_W-1:0] RdData2,
    output logic              Wrote,
    output logic [ADDR_W-1:0] WroteReg
);

    localparam int NREG = 2 ** ADDR_W;

    // Flops rather than RAM so the whole array clears asynchronously.
    logic [DATA_W-1:0] regs [NREG];
    logic              commit;

    assign commit = RegWrite && (WriteReg != '0);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (commit) begin
            regs[WriteReg] <= WriteData;
        end
    end

    // Bypass keeps a same-cycle write coherent with the A/B capture.
    always_comb begin
        RdData1 = regs[ReadReg1];
        if (ReadReg1 == '0) begin
            RdData1 = '0;
        end else if (RegWrite && (WriteReg == ReadReg1)) begin
            RdData1 = WriteData;
        end
    end

    always_comb begin
        RdData2 = regs[ReadReg2];
        if (ReadReg2 == '0) begin
            RdData2 = '0;
        end else if (RegWrite && (WriteReg == ReadReg2)) begin
            RdData2 = WriteData;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            A <= '0;
            B <= '0;
        end else begin
            if (LatchA) begin
                A <= RdData1;
            end
            if (LatchB) begin
                B <= RdData2;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Wrote    <= 1'b0;
            WroteReg <= '0;
        end else begin
            Wrote <= commit;
            if (commit) begin
                WroteReg <= WriteReg;
            end
        end
    end

endmodule

// File: doc/regfile_ab_latch.md
Name: regfile_ab_latch

Overview:
- Integer register file for the multicycle CPU datapath: 32 registers x 32 bits, two read ports, one write port.
- Also holds the A/B operand latches that sit between register read and the ALU.
- The write address is the 5-bit destination register chosen upstream: rt or rd for ALU/load results, or r31 for link.
- Writes happen in the write-back cycle. A/B are captured in the decode cycle under control-FSM enables.

Parameters:
- DATA_W, 32, register and data width
- ADDR_W, 5, register index width (number of registers = 2**ADDR_W)

Ports:
- Clk  input  1  rising-edge clock
- Rst_n  input  1  asynchronous active-low reset
- RegWrite  input  1  write enable for the write-back cycle
- WriteReg  input  ADDR_W  destination register index
- WriteData  input  DATA_W  write-back value
- ReadReg1  input  ADDR_W  source index for port A (rs)
- ReadReg2  input  ADDR_W  source index for port B (rt)
- LatchA  input  1  capture port-A read value into A
- LatchB  input  1  capture port-B read value into B
- A  output  DATA_W  registered operand A
- B  output  DATA_W  registered operand B
- RdData1  output  DATA_W  combinational read of ReadReg1, with bypass
- RdData2  output  DATA_W  combinational read of ReadReg2, with bypass
- Wrote  output  1  registered pulse, high one cycle after a committed write (write to r0 excluded)
- WroteReg  output  ADDR_W  index of the last committed write; holds its value between writes

Behaviour:
- Reset (Rst_n=0, asynchronous, takes effect immediately):
  - all 32 registers = 0
  - A = 0, B = 0, Wrote = 0, WroteReg = 0
  - RdData1/RdData2 therefore read 0
- On release, the first active edge is the first edge where Rst_n=1. No synchronous residue.
- Register 0 is hardwired to zero:
  - a write with WriteReg=0 is discarded
  - Wrote stays 0 for that write
  - reads of index 0 always return 0
- Write: at a rising Clk with RegWrite=1 and WriteReg!=0, reg[WriteReg] <= WriteData. Visible in array reads from the next cycle.
- Combinational read with bypass:
  - RdDataN = 0 if ReadRegN = 0
  - else WriteData if RegWrite=1 and WriteReg = ReadRegN
  - else reg[ReadRegN]
  - The bypass makes same-cycle write-then-read coherent for the A/B latches.
- Latches:
  - at a rising Clk, LatchA=1 gives A <= RdData1, and LatchB=1 gives B <= RdData2
  - otherwise A and B hold
  - A and B latch independently; both may latch in the same cycle
  - a latch in the same cycle as a write to the same index captures the new WriteData (bypass value)
- Wrote / WroteReg:
  - on an edge with a committed write: Wrote <= 1, WroteReg <= WriteReg
  - otherwise Wrote <= 0 and WroteReg holds
- Latency: write to array read is 1 cycle. Write to latched A/B is 0 extra cycles via bypass.
- Simultaneous events:
  - write plus both latches on the same index: A = B = WriteData after the edge
  - ReadReg1 = ReadReg2: both ports return the same value
- Reset mid-operation: a pending write at the same instant as Rst_n falling is lost. The reset value wins.
- Implementation: the array is flops, not inferred RAM, because of the asynchronous clear.

Test Plan:
- Reset then read all 32 indices -> RdData1/RdData2 = 0, A = B = 0, Wrote = 0.
- Write WriteReg=5, WriteData=0xDEADBEEF; next cycle ReadReg1=5, LatchA=1 -> RdData1 = 0xDEADBEEF, A = 0xDEADBEEF after the edge, Wrote pulses 1 for one cycle with WroteReg = 5.
- Write WriteReg=0, WriteData=0x12345678; read index 0 -> RdData = 0, Wrote stays 0, WroteReg unchanged.
- Same cycle: RegWrite=1, WriteReg=9, WriteData=0xA5A5A5A5, ReadReg1=ReadReg2=9, LatchA=LatchB=1 -> after the edge A = B = 0xA5A5A5A5, and reg 9 reads 0xA5A5A5A5 next cycle.
- Load reg31=0x00400008 and reg7=0x7, then hold LatchA=LatchB=0 while writing reg7=0x99 -> A and B keep their prior values; re-latch with ReadReg2=7 -> B = 0x99.
- Write reg3=0xFFFFFFFF, then assert Rst_n=0 mid-cycle with RegWrite=1 pending -> reg3, A, B, Wrote and WroteReg go to 0 immediately, before any clock edge; after release, reg3 reads 0.
